sd_deser_arbiter: RTL and testbench

//  Packet-locked round-robin arbiter that lets NUM_CH serial requesters share one

---
 rtl/sd_deser_arbiter.sv | 115 +++++++++++
 tb/tb_sd_deser_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_deser_arbiter.sv
// Packet-locked round-robin arbiter feeding one serial deserializer.
// A grant is held from a frame's first beat until its end-of-frame beat transfers.
module sd_deser_arbiter #(
  parameter  int NUM_CH    = 4,
  parameter  int SER_WIDTH = 8,
  localparam int CH_SZ     = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           c_srdy,
  input  logic [NUM_CH*SER_WIDTH-1:0] c_data,
  input  logic [NUM_CH-1:0]           c_ef,
  output logic [NUM_CH-1:0]           c_drdy,
  output logic                        p_srdy,
  output logic [SER_WIDTH-1:0]        p_data,
  output logic                        p_ef,
  input  logic                        p_drdy,
  output logic [CH_SZ-1:0]            p_chan,
  output logic                        p_lock
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           r_st;
  state_t           w_st_nxt;
  logic [CH_SZ-1:0] r_cur_ch;
  logic [CH_SZ-1:0] r_last_ch;
  logic [CH_SZ-1:0] w_cur_nxt;
  logic [CH_SZ-1:0] w_last_nxt;

  logic [CH_SZ-1:0]     w_sel;
  logic [CH_SZ-1:0]     w_cand;
  logic                 w_hit;
  logic                 w_xfer;
  logic [SER_WIDTH-1:0] w_data_arr [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_data_arr[i] = c_data[i*SER_WIDTH +: SER_WIDTH];
    end
  end

  // Channel selection: locked channel while in a frame, else rotate from last_ch+1.
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    w_sel  = r_cur_ch;
    w_cand = r_cur_ch;
    w_hit  = 1'b0;
    if (r_st == ST_IDLE) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        w_cand = CH_SZ'((int'(r_last_ch) + i) % NUM_CH);
        if (!w_hit && c_srdy[w_cand]) begin
          w_hit = 1'b1;
          w_sel = w_cand;
        end
      end
    end
  end

  always_comb begin
    p_srdy         = c_srdy[w_sel];
    p_data         = w_data_arr[w_sel];
    p_ef           = c_ef[w_sel];
    p_chan         = w_sel;
    p_lock         = (r_st == ST_LOCK);
    c_drdy         = '0;
    c_drdy[w_sel]  = p_drdy & c_srdy[w_sel];
  end

  assign w_xfer = p_srdy & p_drdy;

  always_comb begin
    w_st_nxt   = r_st;
    w_cur_nxt  = r_cur_ch;
    w_last_nxt = r_last_ch;
    unique case (r_st)
      ST_IDLE: begin
        if (w_xfer) begin
          w_cur_nxt = w_sel;
          if (p_ef) begin
            w_last_nxt = w_sel;
          end else begin
            w_st_nxt = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (w_xfer && p_ef) begin
          w_st_nxt   = ST_IDLE;
          w_last_nxt = r_cur_ch;
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  // last_ch resets to the top channel so channel 0 wins the first search.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_st      <= ST_IDLE;
      r_cur_ch  <= '0;
      r_last_ch <= CH_SZ'(NUM_CH - 1);
    end else begin
      r_st      <= w_st_nxt;
      r_cur_ch  <= w_cur_nxt;
      r_last_ch <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_sd_deser_arbiter.sv
// Directed bench for sd_deser_arbiter: expected beats are queued as stimulus is
// issued and a negedge monitor pops and compares every transferred beat.
module tb_sd_deser_arbiter;

  localparam int NUM_CH    = 4;
  localparam int SER_WIDTH = 8;
  localparam int CH_SZ     = 2;
  localparam int BEAT_W    = CH_SZ + SER_WIDTH + 1;

  logic                        clk;
  logic                        reset;
  logic [NUM_CH-1:0]           c_srdy;
  logic [NUM_CH*SER_WIDTH-1:0] c_data;
  logic [NUM_CH-1:0]           c_ef;
  logic [NUM_CH-1:0]           c_drdy;
  logic                        p_srdy;
  logic [SER_WIDTH-1:0]        p_data;
  logic                        p_ef;
  logic                        p_drdy;
  logic [CH_SZ-1:0]            p_chan;
  logic                        p_lock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BEAT_W-1:0] exp_q [$];
  logic [BEAT_W-1:0] mon_exp;

  sd_deser_arbiter #(.NUM_CH(NUM_CH), .SER_WIDTH(SER_WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_data (c_data),
    .c_ef   (c_ef),
    .c_drdy (c_drdy),
    .p_srdy (p_srdy),
    .p_data (p_data),
    .p_ef   (p_ef),
    .p_drdy (p_drdy),
    .p_chan (p_chan),
    .p_lock (p_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic srdy, input logic [SER_WIDTH-1:0] d,
                        input logic ef);
    c_srdy[ch]                         = srdy;
    c_data[ch*SER_WIDTH +: SER_WIDTH]  = d;
    c_ef[ch]                           = ef;
  endtask

  task automatic expect_beat(input logic [CH_SZ-1:0] ch, input logic [SER_WIDTH-1:0] d,
                             input logic ef);
    exp_q.push_back({ch, d, ef});
  endtask

  // Monitor: every beat the deserializer accepts must match the queue head.
  always @(negedge clk) begin
    if (!reset && p_srdy && p_drdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_unexpected: got chan=%0d data=%h ef=%b expected no beat at %0t",
                 p_chan, p_data, p_ef, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", 32'({p_chan, p_data, p_ef}), 32'(mon_exp));
      end
    end
  end

  initial begin
    reset  = 1'b1;
    c_srdy = '0;
    c_data = '0;
    c_ef   = '0;
    p_drdy = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // 1: reset state, then ch0 beats ch3 because last_ch resets to 3
    mid();
    check("rst_p_srdy", 32'(p_srdy), 32'd0);
    check("rst_c_drdy", 32'(c_drdy), 32'b0000);
    check("rst_p_lock", 32'(p_lock), 32'd0);
    check("rst_p_chan", 32'(p_chan), 32'd0);
    tick();
    set_ch(0, 1'b1, 8'h10, 1'b1);
    set_ch(3, 1'b1, 8'h13, 1'b1);
    expect_beat(2'd0, 8'h10, 1'b1);
    mid();
    check("first_grant_drdy", 32'(c_drdy), 32'b0001);
    tick();
    set_ch(0, 1'b0, 8'h00, 1'b0);
    expect_beat(2'd3, 8'h13, 1'b1);
    mid();
    tick();
    set_ch(3, 1'b0, 8'h00, 1'b0);

    // 2: three-beat frame on ch2, with a p_drdy stall while idle first
    set_ch(2, 1'b1, 8'hA1, 1'b0);
    p_drdy = 1'b0;
    mid();
    check("stall_p_srdy", 32'(p_srdy), 32'd1);
    check("stall_c_drdy", 32'(c_drdy), 32'b0000);
    check("stall_p_chan", 32'(p_chan), 32'd2);
    tick();
    p_drdy = 1'b1;
    expect_beat(2'd2, 8'hA1, 1'b0);
    mid();
    check("stall_no_lock", 32'(p_lock), 32'd0);
    tick();
    set_ch(2, 1'b1, 8'hA2, 1'b0);
    expect_beat(2'd2, 8'hA2, 1'b0);
    mid();
    check("a_lock_after_a1", 32'(p_lock), 32'd1);
    tick();
    set_ch(2, 1'b1, 8'hA3, 1'b1);
    expect_beat(2'd2, 8'hA3, 1'b1);
    mid();
    tick();
    set_ch(2, 1'b0, 8'h00, 1'b0);
    mid();
    check("a_unlock_after_a3", 32'(p_lock), 32'd0);
    tick();

    // 3: ch1 requests during ch0 frame and must wait for ch0 ef
    set_ch(0, 1'b1, 8'hB0, 1'b0);
    expect_beat(2'd0, 8'hB0, 1'b0);
    mid();
    tick();
    set_ch(0, 1'b1, 8'hB1, 1'b1);
    set_ch(1, 1'b1, 8'hC0, 1'b0);
    expect_beat(2'd0, 8'hB1, 1'b1);
    mid();
    check("b_ch1_held", 32'(c_drdy), 32'b0001);
    tick();
    set_ch(0, 1'b0, 8'h00, 1'b0);
    expect_beat(2'd1, 8'hC0, 1'b0);
    mid();
    check("c_ch1_granted", 32'(c_drdy), 32'b0010);
    tick();
    set_ch(1, 1'b1, 8'hC1, 1'b1);
    expect_beat(2'd1, 8'hC1, 1'b1);
    mid();
    tick();
    set_ch(1, 1'b0, 8'h00, 1'b0);

    // 4: single beat on ch3 moves last_ch to 3, then all four rotate 0,1,2,3,0,1
    set_ch(3, 1'b1, 8'hD3, 1'b1);
    expect_beat(2'd3, 8'hD3, 1'b1);
    mid();
    tick();
    for (int ch = 0; ch < NUM_CH; ch++) set_ch(ch, 1'b1, 8'(8'h40 + ch), 1'b1);
    for (int k = 0; k < 6; k++) begin
      expect_beat(CH_SZ'(k % NUM_CH), 8'(8'h40 + (k % NUM_CH)), 1'b1);
      mid();
      check("rr_p_lock", 32'(p_lock), 32'd0);
      tick();
    end
    c_srdy = '0;
    c_ef   = '0;

    // 5: ch3 locked, bubbles while ch0 waits with its ef raised
    set_ch(3, 1'b1, 8'hE1, 1'b0);
    expect_beat(2'd3, 8'hE1, 1'b0);
    mid();
    tick();
    set_ch(3, 1'b0, 8'h00, 1'b0);
    set_ch(0, 1'b1, 8'hF0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      mid();
      check("bubble_p_srdy", 32'(p_srdy), 32'd0);
      check("bubble_p_chan", 32'(p_chan), 32'd3);
      check("bubble_c_drdy", 32'(c_drdy), 32'b0000);
      check("bubble_p_ef", 32'(p_ef), 32'd0);
      check("bubble_p_lock", 32'(p_lock), 32'd1);
      tick();
    end
    set_ch(3, 1'b1, 8'hE2, 1'b1);
    expect_beat(2'd3, 8'hE2, 1'b1);
    mid();
    check("e_end_c_drdy", 32'(c_drdy), 32'b1000);
    tick();
    set_ch(3, 1'b0, 8'h00, 1'b0);
    expect_beat(2'd0, 8'hF0, 1'b1);
    mid();
    check("f_ch0_granted", 32'(c_drdy), 32'b0001);
    tick();
    set_ch(0, 1'b0, 8'h00, 1'b0);

    // 6: reset mid-frame on ch1, then ch2 served from a clean idle state
    set_ch(1, 1'b1, 8'h61, 1'b0);
    expect_beat(2'd1, 8'h61, 1'b0);
    mid();
    tick();
    reset = 1'b1;
    set_ch(1, 1'b1, 8'h62, 1'b0);
    mid();
    tick();
    reset = 1'b0;
    set_ch(1, 1'b0, 8'h00, 1'b0);
    set_ch(2, 1'b1, 8'h72, 1'b1);
    expect_beat(2'd2, 8'h72, 1'b1);
    mid();
    check("post_rst_p_lock", 32'(p_lock), 32'd0);
    check("post_rst_p_chan", 32'(p_chan), 32'd2);
    check("post_rst_c_drdy", 32'(c_drdy), 32'b0100);
    tick();
    set_ch(2, 1'b0, 8'h00, 1'b0);
    set_ch(0, 1'b1, 8'h80, 1'b1);
    set_ch(3, 1'b1, 8'h83, 1'b1);
    expect_beat(2'd3, 8'h83, 1'b1);
    mid();
    tick();
    set_ch(3, 1'b0, 8'h00, 1'b0);
    expect_beat(2'd0, 8'h80, 1'b1);
    mid();
    tick();
    set_ch(0, 1'b0, 8'h00, 1'b0);

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
